accum_seq: RTL and testbench
============================

Name: accum_seq

Overview:
- Control FSM that sequences the partial-sum accumulator for one conv layer.
- Loads one bias per output channel and streams PE results over all input channels.
- Drives the accumulator's first/last/channel-counter/enable strobes and flags the final pass so that Mout_data is written back.
- Sits between the layer controller (start/cfg/done) and the accumulator + PE result stream.

Parameters:
- CH_W, 16, width of channel counters and channel config.
- PIX_W, 16, width of the per-channel pixel count.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- cfg_in_ch  in  CH_W  number of input channels (≥1)
- cfg_out_ch  in  CH_W  number of output channels (≥1)
- cfg_pix  in  PIX_W  result beats per input channel (≥1)
- res_valid  in  1  PE result valid this cycle
- bias_req  out  1  request next bias word
- bias_valid  in  1  bias word present on accumulator mb_in
- mb_push  out  1  latch bias into accumulator
- out_en  out  1  accept current PE result (accumulator enable)
- first  out  1  data in accumulator pipeline reg belongs to input ch 0
- last  out  1  data in accumulator pipeline reg belongs to final input ch
- in_ch_cnt  out  CH_W  current input channel index
- out_ch_cnt  out  CH_W  current output channel index
- out_ch_c  out  1  one-cycle pulse when out_ch_cnt advances
- out_state  out  1  high while streaming the final input channel
- mout_valid  out  1  accumulator Mout_data valid (final sum + bias)
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse at layer end

Behaviour:
- Reset (rst=0 at posedge): state IDLE; all outputs 0; counters 0. Reset mid-operation aborts immediately with no done pulse.
- cfg_* sampled into internal regs on accepted start; later changes are ignored until the next start.
- States:
  - IDLE: start → BIAS, busy=1.
  - BIAS: bias_req=1; on bias_valid → mb_push=1 for that cycle, go to ACC.
  - ACC: out_en = res_valid. Each beat increments pix_cnt. On the beat with pix_cnt==cfg_pix-1 → pix_cnt=0, go to GAP.
  - GAP: exactly one cycle; out_en=0, res_valid ignored (PE must not issue here).
    - If in_ch_cnt < cfg_in_ch-1: in_ch_cnt++, go to ACC.
    - Else: in_ch_cnt=0. If out_ch_cnt < cfg_out_ch-1: out_ch_cnt++, out_ch_c=1, go to BIAS; else go to DONE.
  - DONE: done=1, busy=0, go to IDLE.
- The in_ch_cnt change in GAP restarts the accumulator's partial-sum read address at 0; GAP guarantees no beat coincides with the change.
- Alignment: the accumulator registers results one cycle.
  - first, last and mout_valid are registered one cycle after the out_en beat they qualify.
  - first = beat had in_ch 0.
  - last = beat had in_ch cfg_in_ch-1.
  - mout_valid = out_en_d & last.
- cfg_in_ch=1: first and last are both high on every delayed beat.
- out_state = (state==ACC) & (in_ch_cnt==cfg_in_ch-1).
- Counter widths are exact; cfg value 0 is illegal and is treated as 1 (no wrap).
- start while busy is ignored.
- res_valid outside ACC is ignored (out_en=0).
- bias_valid outside BIAS is ignored.

Decomposition:
- Shared package holds:
  - state enum: IDLE, BIAS, ACC, GAP, DONE.
  - CH_W and PIX_W defaults.
- Sub-module: one generic up-counter with terminal-count flag, named cnt_tc. It is instantiated for the pixel, input-channel and output-channel counters.
- FSM and alignment registers stay in the top module.

Test Plan:
- cfg_in_ch=2, cfg_out_ch=1, cfg_pix=3, continuous res_valid:
  - One mb_push, then 3 out_en beats, GAP, then 3 more.
  - first high on delayed beats 1–3; last high on 4–6; mout_valid exactly 3 cycles.
  - done 1 cycle after final GAP.
- cfg_out_ch=3:
  - 3 bias_req/mb_push handshakes.
  - out_ch_c pulses twice; out_ch_cnt sequence 0,1,2; total out_en beats = 3·cfg_in_ch·cfg_pix.
- res_valid gapped at 50% duty with bias_valid delayed 4 cycles:
  - beat counts unchanged; no out_en during BIAS or GAP; bias_req held until bias_valid.
- cfg_in_ch=1, cfg_pix=1: first and last both high on each delayed beat; mout_valid once per output channel.
- rst low during ACC of in_ch 1: next cycle all outputs 0 and state IDLE; no done pulse. A fresh start then runs the full sequence.
- start pulsed while busy and cfg changed mid-run: no effect on the sequence or counts.

Source files
------------

// File: rtl/accum_seq_pkg.sv
// Shared types and default widths for the partial-sum accumulator sequencer.
package accum_seq_pkg;

    localparam int CH_W_DEF  = 16;
    localparam int PIX_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        BIAS,
        ACC,
        GAP,
        DONE
    } state_t;

endpackage

// File: rtl/accum_seq_if.sv
// Sequencer-facing bundle: layer controller handshake, PE/bias stream and accumulator strobes.
interface accum_seq_if
    import accum_seq_pkg::*;
#(
    parameter int CH_W  = CH_W_DEF,
    parameter int PIX_W = PIX_W_DEF
);
    logic             start;
    logic [CH_W-1:0]  cfg_in_ch;
    logic [CH_W-1:0]  cfg_out_ch;
    logic [PIX_W-1:0] cfg_pix;
    logic             res_valid;
    logic             bias_req;
    logic             bias_valid;
    logic             mb_push;
    logic             out_en;
    logic             first;
    logic             last;
    logic [CH_W-1:0]  in_ch_cnt;
    logic [CH_W-1:0]  out_ch_cnt;
    logic             out_ch_c;
    logic             out_state;
    logic             mout_valid;
    logic             busy;
    logic             done;

    // master is the sequencer itself; slave is the controller/accumulator side
    modport master (
        input  start, cfg_in_ch, cfg_out_ch, cfg_pix, res_valid, bias_valid,
        output bias_req, mb_push, out_en, first, last, in_ch_cnt, out_ch_cnt,
               out_ch_c, out_state, mout_valid, busy, done
    );

    modport slave (
        output start, cfg_in_ch, cfg_out_ch, cfg_pix, res_valid, bias_valid,
        input  bias_req, mb_push, out_en, first, last, in_ch_cnt, out_ch_cnt,
               out_ch_c, out_state, mout_valid, busy, done
    );

endinterface

// File: rtl/accum_seq_cnt_tc.sv
// Generic up-counter that wraps to zero after reaching tc_val; tc flags the terminal count.
module cnt_tc
    import accum_seq_pkg::*;
#(
    parameter int W = PIX_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] tc_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    assign tc = (cnt == tc_val);

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/accum_seq.sv
// Partial-sum accumulator sequencer: one bias per output channel, then PE beats over all input channels.
//
// state | meaning
// IDLE  | waiting for start
// BIAS  | requesting the bias word for the current output channel
// ACC   | accepting PE result beats for the current input channel
// GAP   | single idle cycle while channel counters advance
// DONE  | one-cycle layer-end pulse
module accum_seq
    import accum_seq_pkg::*;
#(
    parameter int CH_W  = CH_W_DEF,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    accum_seq_if.master bus
);

    state_t           state;
    logic [CH_W-1:0]  in_max;
    logic [CH_W-1:0]  out_max;
    logic [PIX_W-1:0] pix_max;
    logic [CH_W-1:0]  in_cnt;
    logic [CH_W-1:0]  out_cnt;
    logic [PIX_W-1:0] pix_cnt;
    logic             in_tc;
    logic             out_tc;
    logic             pix_tc;
    logic             accept;
    logic             beat;
    logic             push;
    logic             busy_q;
    logic             done_q;
    logic             bias_req_q;
    logic             out_ch_c_q;
    logic             first_q;
    logic             last_q;
    logic             mout_valid_q;

    assign accept = (state == IDLE) && bus.start;
    assign beat   = (state == ACC) && bus.res_valid;
    assign push   = (state == BIAS) && bus.bias_valid;

    // Terminal values are stored as cfg-1; a zero cfg behaves like one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_max  <= '0;
            out_max <= '0;
            pix_max <= '0;
        end else if (accept) begin
            in_max  <= (bus.cfg_in_ch  == '0) ? '0 : bus.cfg_in_ch  - 1'b1;
            out_max <= (bus.cfg_out_ch == '0) ? '0 : bus.cfg_out_ch - 1'b1;
            pix_max <= (bus.cfg_pix    == '0) ? '0 : bus.cfg_pix    - 1'b1;
        end
    end

    cnt_tc #(.W(PIX_W)) u_pix_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .inc    (beat),
        .tc_val (pix_max),
        .cnt    (pix_cnt),
        .tc     (pix_tc)
    );

    cnt_tc #(.W(CH_W)) u_in_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .inc    (state == GAP),
        .tc_val (in_max),
        .cnt    (in_cnt),
        .tc     (in_tc)
    );

    cnt_tc #(.W(CH_W)) u_out_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .inc    ((state == GAP) && in_tc),
        .tc_val (out_max),
        .cnt    (out_cnt),
        .tc     (out_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            bias_req_q   <= 1'b0;
            out_ch_c_q   <= 1'b0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            mout_valid_q <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            out_ch_c_q   <= 1'b0;
            // The accumulator holds each beat one cycle, so its qualifiers trail by one.
            first_q      <= beat && (in_cnt == '0);
            last_q       <= beat && in_tc;
            mout_valid_q <= beat && in_tc;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= BIAS;
                        busy_q     <= 1'b1;
                        bias_req_q <= 1'b1;
                    end
                end
                BIAS: begin
                    if (bus.bias_valid) begin
                        state      <= ACC;
                        bias_req_q <= 1'b0;
                    end
                end
                ACC: begin
                    if (beat && pix_tc) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (!in_tc) begin
                        state <= ACC;
                    end else if (!out_tc) begin
                        state      <= BIAS;
                        bias_req_q <= 1'b1;
                        out_ch_c_q <= 1'b1;
                    end else begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.bias_req   = bias_req_q;
    assign bus.mb_push    = push;
    assign bus.out_en     = beat;
    assign bus.first      = first_q;
    assign bus.last       = last_q;
    assign bus.in_ch_cnt  = in_cnt;
    assign bus.out_ch_cnt = out_cnt;
    assign bus.out_ch_c   = out_ch_c_q;
    assign bus.out_state  = (state == ACC) && in_tc;
    assign bus.mout_valid = mout_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_accum_seq.sv
// Directed bench for accum_seq: per-beat channel/alignment checks plus per-run event totals.
module tb_accum_seq;

    localparam int CH_W  = 16;
    localparam int PIX_W = 16;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    int   rv_mode  = 0;
    int   bdelay   = 0;
    bit   b_always = 1'b0;
    int   age      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    accum_seq_if #(.CH_W(CH_W), .PIX_W(PIX_W)) bus ();

    accum_seq #(.CH_W(CH_W), .PIX_W(PIX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // PE result and bias source models
    always @(posedge clk) begin
        #1;
        if (bus.bias_req) age = age + 1;
        else              age = 0;
        bus.bias_valid = b_always || (bus.bias_req && (age > bdelay));
        case (rv_mode)
            0:       bus.res_valid = 1'b0;
            1:       bus.res_valid = 1'b1;
            default: bus.res_valid = ~bus.res_valid;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_flags"},
              {bus.busy, bus.done, bus.bias_req, bus.mb_push, bus.out_en, bus.first,
               bus.last, bus.out_ch_c, bus.out_state, bus.mout_valid}, 0);
        check({tag, "_in_ch"},  bus.in_ch_cnt, 0);
        check({tag, "_out_ch"}, bus.out_ch_cnt, 0);
    endtask

    task automatic run(input int ci, input int co, input int cp, input int rvm, input int bd,
                       input bit ba, input bit abort, input bit disturb);
        int mi, mo, mp, k, t, prev_cyc;
        int n_oen, n_push, n_req, n_occ, n_mout, n_fl, n_done;
        bit p_oen, p_first, p_last, p_req, p_push, got_done, aborted;
        mi = (ci == 0) ? 1 : ci;
        mo = (co == 0) ? 1 : co;
        mp = (cp == 0) ? 1 : cp;
        k = 0; t = 0; prev_cyc = 0;
        n_oen = 0; n_push = 0; n_req = 0; n_occ = 0; n_mout = 0; n_fl = 0; n_done = 0;
        p_oen = 0; p_first = 0; p_last = 0; p_req = 0; p_push = 0; got_done = 0; aborted = 0;
        rv_mode  = rvm;
        bdelay   = bd;
        b_always = ba;
        bus.cfg_in_ch  = CH_W'(ci);
        bus.cfg_out_ch = CH_W'(co);
        bus.cfg_pix    = PIX_W'(cp);
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        while (!got_done && t < 3000) begin
            @(negedge clk);
            t++;
            if (disturb && t == 5) begin
                bus.start      = 1'b1;
                bus.cfg_in_ch  = CH_W'(5);
                bus.cfg_out_ch = CH_W'(4);
                bus.cfg_pix    = PIX_W'(7);
            end
            if (disturb && t == 6) bus.start = 1'b0;

            if (p_oen) begin
                check("first_d", bus.first, p_first);
                check("last_d", bus.last, p_last);
                check("mout_d", bus.mout_valid, p_last);
            end else begin
                check("dly_quiet", {bus.first, bus.last, bus.mout_valid}, 0);
            end
            if (bus.first && bus.last) n_fl++;
            if (bus.mout_valid) n_mout++;
            if (bus.bias_req) n_req++;
            if (p_req && !p_push) check("req_hold", bus.bias_req, 1);
            if (bus.mb_push) begin
                check("push_valid", bus.bias_valid, 1);
                check("push_req", bus.bias_req, 1);
                check("push_och", bus.out_ch_cnt, n_push);
                n_push++;
            end
            if (bus.out_ch_c) begin
                n_occ++;
                check("occ_och", bus.out_ch_cnt, n_occ);
            end
            if (bus.out_en) begin
                check("oen_rv", bus.res_valid, 1);
                check("oen_req", bus.bias_req, 0);
                check("beat_in_ch", bus.in_ch_cnt, (k / mp) % mi);
                check("beat_out_ch", bus.out_ch_cnt, k / (mi * mp));
                check("beat_ostate", bus.out_state, ((k / mp) % mi) == mi - 1);
                check("beat_busy", bus.busy, 1);
                if (rvm == 1 && k > 0) begin
                    if (k % (mi * mp) == 0) begin
                        if (ba) check("bias_gap", cyc - prev_cyc, 3);
                    end else if (k % mp == 0) begin
                        check("gap_len", cyc - prev_cyc, 2);
                    end else begin
                        check("beat_gap", cyc - prev_cyc, 1);
                    end
                end
                p_first  = ((k / mp) % mi) == 0;
                p_last   = ((k / mp) % mi) == mi - 1;
                prev_cyc = cyc;
                k++;
                n_oen++;
            end
            if (bus.done) begin
                got_done = 1;
                n_done++;
                check("done_busy", bus.busy, 0);
                check("done_lat", cyc - prev_cyc, 2);
            end
            p_oen  = bus.out_en;
            p_req  = bus.bias_req;
            p_push = bus.mb_push;
            if (abort && k == mp + 1) begin
                aborted = 1;
                break;
            end
        end

        if (aborted) begin
            rst = 1'b0;
            @(negedge clk);
            check_idle("abort");
            @(negedge clk);
            check_idle("abort_hold");
            rst = 1'b1;
            @(negedge clk);
            check_idle("abort_rel");
        end else begin
            check("done_seen", got_done, 1);
            check("n_oen", n_oen, mo * mi * mp);
            check("n_push", n_push, mo);
            check("n_occ", n_occ, mo - 1);
            check("n_mout", n_mout, mo * mp);
            check("n_req", n_req, mo * (bd + 1));
            check("n_fl", n_fl, (mi == 1) ? mo * mp : 0);
            check("n_done", n_done, 1);
            @(negedge clk);
            check_idle("post");
        end
    endtask

    initial begin
        rst            = 1'b0;
        bus.start      = 1'b0;
        bus.cfg_in_ch  = '0;
        bus.cfg_out_ch = '0;
        bus.cfg_pix    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        rst = 1'b1;
        @(negedge clk);

        //   in out pix rv bd always abort disturb
        run(2, 1, 3, 1, 0, 1, 0, 0);
        run(2, 3, 2, 1, 0, 1, 0, 0);
        run(3, 2, 2, 2, 4, 0, 0, 0);
        run(1, 2, 1, 1, 0, 1, 0, 0);
        run(2, 2, 4, 1, 0, 1, 1, 0);
        run(2, 2, 4, 1, 0, 1, 0, 0);
        run(0, 0, 2, 1, 0, 1, 0, 0);
        run(2, 2, 3, 1, 0, 1, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
